// File: rtl/rpn_alu.sv
// rpn_alu: reverse-Polish evaluation engine driving an external stack port.
// Define RPN_ALU_MUL_EN to enable opcode 2 (MUL); otherwise opcode 2 errors.
module rpn_alu #(
    parameter int DEPTH = 256,
    parameter int DWID  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tok_valid,
    output logic                   tok_ready,
    input  logic                   tok_is_op,
    input  logic [DWID-1:0]        tok_data,
    output logic [DWID-1:0]        res,
    output logic                   res_v,
    output logic                   err,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [DWID-1:0]        stk_din,
    input  logic [DWID-1:0]        stk_dout,
    input  logic                   stk_dout_v
);
    localparam int AW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] FULL = AW'(DEPTH);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] TWO  = AW'(2);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POPB  = 3'd1;
    localparam logic [2:0] WAITB = 3'd2;
    localparam logic [2:0] POPA  = 3'd3;
    localparam logic [2:0] WAITA = 3'd4;
    localparam logic [2:0] PUSH  = 3'd5;
    localparam logic [2:0] PUSH2 = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_DROP = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [DWID-1:0] b_q, b_d;
    logic [DWID-1:0] din_q, din_d;
    logic [DWID-1:0] res_q, res_d;
    logic            push_q, push_d;
    logic            pop_q, pop_d;
    logic            res_v_q, res_v_d;
    logic            err_q, err_d;
    logic [AW-1:0]   depth_q, depth_d;
    logic            op_ok;
    logic [DWID-1:0] alu;

    // Occupancy checks for an operator token, made against the mirrored count
    always_comb begin
        op_ok = 1'b0;
        case (tok_data[2:0])
            OP_DUP:  op_ok = (depth_q >= ONE) && (depth_q < FULL);
            OP_DROP: op_ok = (depth_q >= ONE);
`ifdef RPN_ALU_MUL_EN
            OP_MUL:  op_ok = (depth_q >= TWO);
`else
            OP_MUL:  op_ok = 1'b0;
`endif
            default: op_ok = (depth_q >= TWO);
        endcase
    end

    // a arrives on stk_dout in WAITA; b was captured earlier
    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD:  alu = stk_dout + b_q;
            OP_SUB:  alu = stk_dout - b_q;
`ifdef RPN_ALU_MUL_EN
            OP_MUL:  alu = stk_dout * b_q;
`endif
            OP_AND:  alu = stk_dout & b_q;
            OP_OR:   alu = stk_dout | b_q;
            OP_XOR:  alu = stk_dout ^ b_q;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        din_d   = din_q;
        res_d   = res_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        res_v_d = 1'b0;
        err_d   = 1'b0;
        depth_d = depth_q;
        if (push_q) begin
            depth_d = depth_q + ONE;
        end else if (pop_q) begin
            depth_d = depth_q - ONE;
        end
        unique case (state_q)
            IDLE: begin
                if (tok_valid && !tok_is_op) begin
                    op_d = OP_ADD;
                    if (depth_q < FULL) begin
                        din_d   = tok_data;
                        push_d  = 1'b1;
                        state_d = PUSH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end else if (tok_valid) begin
                    op_d = tok_data[2:0];
                    if (op_ok) begin
                        pop_d   = 1'b1;
                        state_d = POPB;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            POPB: state_d = WAITB;
            WAITB: begin
                if (stk_dout_v) begin
                    b_d = stk_dout;
                    if (op_q == OP_DUP) begin
                        din_d   = stk_dout;
                        res_d   = stk_dout;
                        res_v_d = 1'b1;
                        push_d  = 1'b1;
                        state_d = PUSH;
                    end else if (op_q == OP_DROP) begin
                        state_d = IDLE;
                    end else begin
                        pop_d   = 1'b1;
                        state_d = POPA;
                    end
                end
            end
            POPA: state_d = WAITA;
            WAITA: begin
                if (stk_dout_v) begin
                    din_d   = alu;
                    res_d   = alu;
                    res_v_d = 1'b1;
                    push_d  = 1'b1;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (op_q == OP_DUP) begin
                    push_d  = 1'b1;
                    state_d = PUSH2;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH2:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            b_q     <= '0;
            din_q   <= '0;
            res_q   <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            res_v_q <= 1'b0;
            err_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            din_q   <= din_d;
            res_q   <= res_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            res_v_q <= res_v_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    assign tok_ready = (state_q == IDLE) && !rst;
    assign res       = res_q;
    assign res_v     = res_v_q;
    assign err       = err_q;
    assign depth     = depth_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_din   = din_q;

endmodule

// File: tb/tb_rpn_alu.sv
// tb_rpn_alu: self-checking bench for rpn_alu with a behavioural stack
// and a queue-based RPN reference model.
module tb_rpn_alu;
    localparam int DEPTH = 8;
    localparam int DWID  = 16;
    localparam int AW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tok_valid = 1'b0;
    logic            tok_ready;
    logic            tok_is_op = 1'b0;
    logic [DWID-1:0] tok_data = '0;
    logic [DWID-1:0] res;
    logic            res_v;
    logic            err;
    logic [AW-1:0]   depth;
    logic            stk_push;
    logic            stk_pop;
    logic [DWID-1:0] stk_din;
    logic [DWID-1:0] stk_dout;
    logic            stk_dout_v;

    rpn_alu #(.DEPTH(DEPTH), .DWID(DWID)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_data(tok_data),
        .res(res), .res_v(res_v), .err(err), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_dout_v(stk_dout_v)
    );

    always #5 clk = ~clk;

    // Attached stack with a programmable read latency (lat >= 1 cycles)
    logic [DWID-1:0] mem [DEPTH];
    int              sp;
    int              rd_cnt;
    int              lat = 1;
    logic [DWID-1:0] rd_data;

    assign stk_dout   = rd_data;
    assign stk_dout_v = (rd_cnt == 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp      <= 0;
            rd_cnt  <= 0;
            rd_data <= '0;
        end else begin
            if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
            if (stk_push && sp < DEPTH) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end else if (stk_pop && sp > 0) begin
                rd_data <= mem[sp-1];
                rd_cnt  <= lat;
                sp      <= sp - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: the stack contents as a queue, top at the back
    logic [DWID-1:0] mq[$];
    logic [DWID-1:0] res_hold;

    function automatic logic [DWID-1:0] ref_alu(input logic [2:0] op,
                                                input logic [DWID-1:0] a,
                                                input logic [DWID-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    int last_nerr;
    int last_nresv;

    task automatic do_tok(input logic isop, input logic [DWID-1:0] d);
        logic [2:0]      op;
        int              n;
        logic            legal;
        logic            e_err;
        int              e_resv_cyc;
        int              e_push, e_pop, e_ready;
        logic [DWID-1:0] a, b, e_res;
        int              cyc, nerr, nresv, npush, npop, both;
        int              err_cyc, resv_cyc, ready_cyc;
        logic            done;
        op = d[2:0];
        n = mq.size();
        e_err = 1'b0; e_resv_cyc = 0; e_push = 0; e_pop = 0;
        e_ready = 2; e_res = res_hold;
        if (!isop) begin
            if (n < DEPTH) begin
                mq.push_back(d);
                e_push = 1;
            end else begin
                e_err = 1'b1;
            end
        end else begin
            case (op)
                3'd6: legal = (n >= 1) && (n < DEPTH);
                3'd7: legal = (n >= 1);
`ifdef RPN_ALU_MUL_EN
                3'd2: legal = (n >= 2);
`else
                3'd2: legal = 1'b0;
`endif
                default: legal = (n >= 2);
            endcase
            if (!legal) begin
                e_err = 1'b1;
            end else if (op == 3'd7) begin
                void'(mq.pop_back());
                e_pop = 1;
                e_ready = 2 + lat;
            end else if (op == 3'd6) begin
                e_res = mq[$];
                mq.push_back(e_res);
                e_pop = 1; e_push = 2;
                e_resv_cyc = 2 + lat;
                e_ready = 4 + lat;
            end else begin
                b = mq.pop_back();
                a = mq.pop_back();
                e_res = ref_alu(op, a, b);
                mq.push_back(e_res);
                e_pop = 2; e_push = 1;
                e_resv_cyc = 3 + 2 * lat;
                e_ready = 4 + 2 * lat;
            end
        end
        res_hold = e_res;

        chk("ready_before_tok", tok_ready, 1);
        tok_valid = 1'b1; tok_is_op = isop; tok_data = d;
        @(posedge clk);
        @(negedge clk);
        tok_valid = 1'b0;
        cyc = 1; done = 1'b0;
        nerr = 0; nresv = 0; npush = 0; npop = 0; both = 0;
        err_cyc = 0; resv_cyc = 0; ready_cyc = 0;
        while (!done && cyc <= 40) begin
            if (res_v) begin nresv++; resv_cyc = cyc; end
            if (err) begin nerr++; err_cyc = cyc; end
            if (stk_push) npush++;
            if (stk_pop) npop++;
            if (stk_push && stk_pop) both++;
            if (tok_ready) begin
                done = 1'b1;
                ready_cyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("token_timeout", done, 1);
        chk("ready_cycle", ready_cyc, e_ready);
        chk("err_count", nerr, e_err ? 1 : 0);
        if (e_err) chk("err_cycle", err_cyc, 1);
        chk("res_v_count", nresv, (e_resv_cyc != 0) ? 1 : 0);
        if (e_resv_cyc != 0) chk("res_v_cycle", resv_cyc, e_resv_cyc);
        chk("res", res, e_res);
        chk("push_count", npush, e_push);
        chk("pop_count", npop, e_pop);
        chk("push_pop_overlap", both, 0);
        chk("depth", depth, mq.size());
        last_nerr = nerr;
        last_nresv = nresv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {res_v, err, stk_push, stk_pop, res, stk_din}, 0);
        chk("rst_depth", depth, 0);
        rst = 1'b0;
        mq.delete();
        res_hold = '0;
        lat = 1;
        @(negedge clk);
        chk("ready_after_rst", tok_ready, 1);
    endtask

    typedef struct {
        logic            isop;
        logic [DWID-1:0] data;
        logic            err;
        logic            resv;
        logic [DWID-1:0] res;
        int              depth;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic isop, input logic [DWID-1:0] data,
                       input logic e, input logic rv,
                       input logic [DWID-1:0] r, input int dp);
        vec_t v;
        v.isop = isop; v.data = data; v.err = e;
        v.resv = rv; v.res = r; v.depth = dp;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        add(1, 16'd0,   1, 0, 16'h0000, 0);
        add(0, 16'd1,   0, 0, 16'h0000, 1);
        add(1, 16'd0,   1, 0, 16'h0000, 1);
        add(1, 16'd7,   0, 0, 16'h0000, 0);
        add(0, 16'd3,   0, 0, 16'h0000, 1);
        add(0, 16'd4,   0, 0, 16'h0000, 2);
        add(1, 16'd0,   0, 1, 16'h0007, 1);
        add(1, 16'd7,   0, 0, 16'h0007, 0);
        add(0, 16'd5,   0, 0, 16'h0007, 1);
        add(0, 16'd9,   0, 0, 16'h0007, 2);
        add(1, 16'd1,   0, 1, 16'hFFFC, 1);
        add(1, 16'd7,   0, 0, 16'hFFFC, 0);
        add(0, 16'h00AA, 0, 0, 16'hFFFC, 1);
        add(1, 16'd6,   0, 1, 16'h00AA, 2);
        add(1, 16'd5,   0, 1, 16'h0000, 1);
        add(1, 16'd7,   0, 0, 16'h0000, 0);
        add(0, 16'd5,   0, 0, 16'h0000, 1);
        add(0, 16'd9,   0, 0, 16'h0000, 2);
        add(1, 16'd1,   0, 1, 16'hFFFC, 1);
        add(0, 16'd2,   0, 0, 16'hFFFC, 2);
`ifdef RPN_ALU_MUL_EN
        add(1, 16'd2,   0, 1, 16'hFFF8, 1);
`else
        add(1, 16'd2,   1, 0, 16'hFFFC, 2);
`endif

        @(negedge clk);
        do_reset();
        foreach (tbl[i]) begin
            do_tok(tbl[i].isop, tbl[i].data);
            chk($sformatf("tbl%0d_err", i), last_nerr != 0, tbl[i].err);
            chk($sformatf("tbl%0d_resv", i), last_nresv, tbl[i].resv);
            chk($sformatf("tbl%0d_res", i), res, tbl[i].res);
            chk($sformatf("tbl%0d_depth", i), depth, tbl[i].depth);
        end

        // Fill to capacity, then overflow, DUP on full, DROP on full
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_tok(1'b0, 16'(i));
        do_tok(1'b0, 16'd99);
        chk("full_push_err", last_nerr, 1);
        chk("full_depth", depth, DEPTH);
        do_tok(1'b1, 16'd6);
        chk("full_dup_err", last_nerr, 1);
        do_tok(1'b1, 16'd7);
        chk("full_drop_resv", last_nresv, 0);
        chk("full_drop_depth", depth, DEPTH - 1);

        // Reset while an ADD waits for operand a
        do_reset();
        lat = 3;
        do_tok(1'b0, 16'd10);
        do_tok(1'b0, 16'd20);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 16'd0;
        @(posedge clk);
        @(negedge clk);
        tok_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {res_v, err, stk_push, stk_pop, res, stk_din}, 0);
        chk("midrst_depth", depth, 0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        res_hold = '0;
        lat = 1;
        @(negedge clk);
        do_tok(1'b0, 16'd2);
        do_tok(1'b0, 16'd3);
        do_tok(1'b1, 16'd3);
        chk("midrst_and_res", res, 2);

        // Randomized tokens with varying read latency
        do_reset();
        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) do_tok(1'b0, 16'($urandom));
            else do_tok(1'b1, 16'($urandom_range(0, 7)));
        end
        chk("final_sp", sp, mq.size());
        for (int i = 0; i < mq.size() && i < DEPTH; i++)
            chk($sformatf("final_stack%0d", i), mem[i], mq[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
